// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/done request bus between a requester and serial_adder_ctrl (SUB with SERIAL_ADDER_SUB_EN)
interface serial_adder_ctrl_if #(parameter int WIDTH = 16);
   logic             START;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
`ifdef SERIAL_ADDER_SUB_EN
   logic             SUB;
`endif
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] SUM;
   logic             COUT;
`ifdef SERIAL_ADDER_SUB_EN
   modport master (output START, A, B, CIN, SUB, input BUSY, DONE, SUM, COUT);
   modport slave  (input START, A, B, CIN, SUB, output BUSY, DONE, SUM, COUT);
`else
   modport master (output START, A, B, CIN, input BUSY, DONE, SUM, COUT);
   modport slave  (input START, A, B, CIN, output BUSY, DONE, SUM, COUT);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit add, one nibble per clock through a single 4-bit ripple adder; SERIAL_ADDER_SUB_EN adds subtract mode
module ripple_carry_adder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);
   logic w_c;
   // Four chained full adders; carry walks from bit 0 to bit 3
   always_comb begin
      w_c   = i_cin;
      o_sum = '0;
      for (int i = 0; i < 4; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
         w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_c;
   end
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input logic                CLK,
   input logic                RST,
   serial_adder_ctrl_if.slave bus
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IW      = $clog2(NIBBLES) + 1;

   if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
   end

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [IW-1:0]    r_idx;
   logic             r_c;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;

   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_nib_mask;
   logic [WIDTH-1:0] w_nib_sum;
   logic [WIDTH-1:0] w_b_in;
   logic             w_c_in;
   logic             w_accept;

   assign w_a_nib    = 4'(r_a >> {r_idx, 2'b00});
   assign w_b_nib    = 4'(r_b >> {r_idx, 2'b00});
   assign w_nib_mask = {{(WIDTH-4){1'b0}}, 4'hF} << {r_idx, 2'b00};
   assign w_nib_sum  = {{(WIDTH-4){1'b0}}, w_s} << {r_idx, 2'b00};
   // The FIN edge doubles as the earliest accept edge, giving one add per NIBBLES+1 cycles
   assign w_accept   = bus.START && (r_state == IDLE || r_state == FIN);

`ifdef SERIAL_ADDER_SUB_EN
   // Subtract as A + ~B + 1; the final carry then means "no borrow"
   assign w_b_in = bus.SUB ? ~bus.B : bus.B;
   assign w_c_in = bus.SUB | bus.CIN;
`else
   assign w_b_in = bus.B;
   assign w_c_in = bus.CIN;
`endif

   ripple_carry_adder u_rca (
      .i_a   (w_a_nib),
      .i_b   (w_b_nib),
      .i_cin (r_c),
      .o_sum (w_s),
      .o_cout(w_co)
   );

   // Sequencer: capture operands, add one nibble per edge with registered carry, pulse DONE once
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_c     <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.A;
         r_b     <= w_b_in;
         r_c     <= w_c_in;
         r_idx   <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_state <= RUN;
      end else begin
         case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               r_done <= 1'b0;
            end
            RUN: begin
               if (r_idx > IW'(NIBBLES - 1)) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_sum <= (r_sum & ~w_nib_mask) | w_nib_sum;
                  r_c   <= w_co;
                  r_idx <= r_idx + 1'b1;
                  if (r_idx == IW'(NIBBLES - 1)) begin
                     r_cout  <= w_co;
                     r_done  <= 1'b1;
                     r_state <= FIN;
                  end
               end
            end
            FIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.BUSY = r_busy;
   assign bus.DONE = r_done;
   assign bus.SUM  = r_sum;
   assign bus.COUT = r_cout;
endmodule
